// File: rtl/cell_painter.sv
// cell_painter: rasterises one filled box into single-pixel writes toward the
// VGA adapter, using a start/busy/done handshake and honouring vga_ready backpressure.
// Optional build macro: CELL_BORDER_EN paints the outer ring of the box in BORDER_COLOR.
module cell_painter #(
   parameter int                  BOX_W        = 64,
   parameter int                  BOX_H        = 24,
   parameter int                  SCREEN_W     = 640,
   parameter int                  SCREEN_H     = 480,
   parameter int                  COLOR_W      = 9,
   parameter logic [COLOR_W-1:0]  BORDER_COLOR = '0
) (
   input  logic               CLOCK_50,
   input  logic               reset,
   input  logic               start,
   input  logic [9:0]         x0,
   input  logic [8:0]         y0,
   input  logic [COLOR_W-1:0] color,
   output logic               busy,
   output logic               done,
   output logic [9:0]         vga_x,
   output logic [8:0]         vga_y,
   output logic [COLOR_W-1:0] vga_color,
   output logic               vga_plot,
   input  logic               vga_ready
);

   typedef enum logic [1:0] {
      IDLE,
      PAINT,
      FINISH
   } state_t;

   localparam int CXW = (BOX_W > 1) ? $clog2(BOX_W) : 1;
   localparam int CYW = (BOX_H > 1) ? $clog2(BOX_H) : 1;

   localparam logic [CXW-1:0] CX_LAST = CXW'(BOX_W - 1);
   localparam logic [CYW-1:0] CY_LAST = CYW'(BOX_H - 1);
   localparam logic [10:0]    SCR_W   = 11'(SCREEN_W);
   localparam logic [9:0]     SCR_H   = 10'(SCREEN_H);

   state_t               state;
   logic [CXW-1:0]       cx;
   logic [CYW-1:0]       cy;
   logic [9:0]           lx0;
   logic [8:0]           ly0;
   logic [COLOR_W-1:0]   lcolor;

   logic [CXW-1:0]       step_cx;
   logic [CYW-1:0]       step_cy;
   logic                 last_pix;
   logic                 advance;
   logic [CXW-1:0]       pix_cx;
   logic [CYW-1:0]       pix_cy;
   logic [9:0]           base_x;
   logic [8:0]           base_y;
   logic [COLOR_W-1:0]   base_color;
   logic [10:0]          sum_x;
   logic [9:0]           sum_y;
   logic                 pix_on;
   logic [COLOR_W-1:0]   pix_color;

   // Next raster position and the pixel that will be presented when the walk moves to it.
   // Outputs are registered, so the pixel for the next (cx,cy) is formed here and loaded
   // on the same edge that loads the counters; in IDLE that is (0,0) of the incoming request.
   always_comb begin
      step_cx    = cx + CXW'(1);
      step_cy    = cy;
      if (cx == CX_LAST) begin
         step_cx = '0;
         step_cy = cy + CYW'(1);
      end
      last_pix   = (cx == CX_LAST) && (cy == CY_LAST);
      advance    = ~vga_plot | vga_ready;

      pix_cx     = step_cx;
      pix_cy     = step_cy;
      base_x     = lx0;
      base_y     = ly0;
      base_color = lcolor;
      if (state == IDLE) begin
         pix_cx     = '0;
         pix_cy     = '0;
         base_x     = x0;
         base_y     = y0;
         base_color = color;
      end

      sum_x  = {1'b0, base_x} + 11'(pix_cx);
      sum_y  = {1'b0, base_y} + 10'(pix_cy);
      pix_on = (sum_x < SCR_W) && (sum_y < SCR_H);
   end

`ifdef CELL_BORDER_EN
   // Outer ring of the box takes the outline colour; interior takes the request colour.
   always_comb begin
      pix_color = base_color;
      if ((pix_cx == '0) || (pix_cx == CX_LAST) || (pix_cy == '0) || (pix_cy == CY_LAST))
         pix_color = BORDER_COLOR;
   end
`else
   logic unused_border;
   assign unused_border = ^BORDER_COLOR;

   // Every pixel takes the request colour.
   always_comb begin
      pix_color = base_color;
   end
`endif

   // Handshake FSM, raster counters and registered pixel port.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state     <= IDLE;
         cx        <= '0;
         cy        <= '0;
         lx0       <= '0;
         ly0       <= '0;
         lcolor    <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         vga_x     <= '0;
         vga_y     <= '0;
         vga_color <= '0;
         vga_plot  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done     <= 1'b0;
               vga_plot <= 1'b0;
               if (start) begin
                  lx0       <= x0;
                  ly0       <= y0;
                  lcolor    <= color;
                  cx        <= '0;
                  cy        <= '0;
                  busy      <= 1'b1;
                  state     <= PAINT;
                  vga_x     <= sum_x[9:0];
                  vga_y     <= sum_y[8:0];
                  vga_color <= pix_color;
                  vga_plot  <= pix_on;
               end
            end
            PAINT: begin
               // A clipped pixel has vga_plot=0, so it always advances; a plotted one
               // holds until the adapter takes it.
               if (advance) begin
                  if (last_pix) begin
                     busy     <= 1'b0;
                     done     <= 1'b1;
                     vga_plot <= 1'b0;
                     state    <= FINISH;
                  end else begin
                     cx        <= step_cx;
                     cy        <= step_cy;
                     vga_x     <= sum_x[9:0];
                     vga_y     <= sum_y[8:0];
                     vga_color <= pix_color;
                     vga_plot  <= pix_on;
                  end
               end
            end
            FINISH: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy     <= 1'b0;
               done     <= 1'b0;
               vga_plot <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule
